// File: rtl/ram_pkg.sv
// Shared bus definitions for the RAM block: word/address bus widths,
// byte-lane geometry and the byte-masked merge helper.
package ram_pkg;

  localparam int MEM_ADDR_BUS_W = 32;  // MemAddrBus
  localparam int WORD_BUS_W     = 32;  // WordBus
  localparam int BYTE_W         = 8;
  localparam int BYTE_LANES     = WORD_BUS_W / BYTE_W;

  typedef logic [MEM_ADDR_BUS_W-1:0] mem_addr_t;
  typedef logic [WORD_BUS_W-1:0]     word_t;
  typedef logic [BYTE_LANES-1:0]     lane_sel_t;

  // Replace the selected byte lanes of 'old_word' with those of 'new_word'.
  function automatic word_t merge_lanes(input word_t old_word,
                                        input word_t new_word,
                                        input lane_sel_t sel);
    word_t result;
    result = old_word;
    for (int n = 0; n < BYTE_LANES; n++) begin
      if (sel[n]) begin
        result[BYTE_W*n +: BYTE_W] = new_word[BYTE_W*n +: BYTE_W];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_byte_lane.sv
// One byte lane of the RAM: DEPTH x 8-bit storage, one synchronous write
// port, two combinational read ports. Contents start at zero and are never
// cleared afterwards.
module ram_byte_lane
  import ram_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int IDX_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [BYTE_W-1:0] w_byte,
  input  logic [IDX_W-1:0]  r_idx1,
  input  logic [IDX_W-1:0]  r_idx2,
  output logic [BYTE_W-1:0] r_byte1,
  output logic [BYTE_W-1:0] r_byte2
);

  logic [BYTE_W-1:0] mem [DEPTH] = '{default: '0};

  // Store the lane byte on the write edge when this lane is enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_idx] <= w_byte;
    end
  end

  assign r_byte1 = mem[r_idx1];
  assign r_byte2 = mem[r_idx2];

endmodule

// File: rtl/ram.sv
// Word-addressed RAM with byte-lane write masking and two independent
// combinational read ports. Addresses wrap modulo RAM_DEPTH.
// Reset (rst_n low) forces both read outputs to zero and blocks writes but
// leaves the stored contents intact.
// Optional macro RAM_WRITE_BYPASS_EN: a read of the word being written shows
// the merged write data in the same cycle instead of the old contents.
module ram
  import ram_pkg::*;
#(
  parameter int RAM_DEPTH         = 16384,
  parameter int RAM_DEPTH_BIT_LEN = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEM_ADDR_BUS_W-1:0] r_addr1_i,
  input  logic [MEM_ADDR_BUS_W-1:0] r_addr2_i,
  input  logic                      w_en_i,
  input  logic [MEM_ADDR_BUS_W-1:0] w_addr_i,
  input  logic [WORD_BUS_W-1:0]     w_data_i,
  input  logic [BYTE_LANES-1:0]     w_sel_i,
  output logic [WORD_BUS_W-1:0]     r_data1_o,
  output logic [WORD_BUS_W-1:0]     r_data2_o
);

  logic [RAM_DEPTH_BIT_LEN-1:0] r_idx1;
  logic [RAM_DEPTH_BIT_LEN-1:0] r_idx2;
  logic [RAM_DEPTH_BIT_LEN-1:0] w_idx;
  logic [BYTE_LANES-1:0]        lane_we;
  logic [WORD_BUS_W-1:0]        stored1;
  logic [WORD_BUS_W-1:0]        stored2;
  logic [WORD_BUS_W-1:0]        rd1;
  logic [WORD_BUS_W-1:0]        rd2;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign r_idx1 = r_addr1_i[RAM_DEPTH_BIT_LEN-1:0];
  assign r_idx2 = r_addr2_i[RAM_DEPTH_BIT_LEN-1:0];
  assign w_idx  = w_addr_i[RAM_DEPTH_BIT_LEN-1:0];

  logic unused_addr_hi;
  assign unused_addr_hi = ^{r_addr1_i[MEM_ADDR_BUS_W-1:RAM_DEPTH_BIT_LEN],
                            r_addr2_i[MEM_ADDR_BUS_W-1:RAM_DEPTH_BIT_LEN],
                            w_addr_i[MEM_ADDR_BUS_W-1:RAM_DEPTH_BIT_LEN]};

  // A lane is written only when enabled, selected and out of reset; the
  // reset term is sampled by the lane's write edge, so writes resume on the
  // first rising edge after rst_n rises.
  assign lane_we = {BYTE_LANES{w_en_i & rst_n}} & w_sel_i;

  for (genvar n = 0; n < BYTE_LANES; n++) begin : g_lane
    ram_byte_lane #(
      .DEPTH (RAM_DEPTH),
      .IDX_W (RAM_DEPTH_BIT_LEN)
    ) u_lane (
      .clk     (clk),
      .we      (lane_we[n]),
      .w_idx   (w_idx),
      .w_byte  (w_data_i[BYTE_W*n +: BYTE_W]),
      .r_idx1  (r_idx1),
      .r_idx2  (r_idx2),
      .r_byte1 (stored1[BYTE_W*n +: BYTE_W]),
      .r_byte2 (stored2[BYTE_W*n +: BYTE_W])
    );
  end

  // Select stored data, or forward the in-flight write when bypass is built in.
  always_comb begin
    rd1 = stored1;
    rd2 = stored2;
`ifdef RAM_WRITE_BYPASS_EN
    if (w_en_i && (r_idx1 == w_idx)) begin
      rd1 = merge_lanes(stored1, w_data_i, w_sel_i);
    end
    if (w_en_i && (r_idx2 == w_idx)) begin
      rd2 = merge_lanes(stored2, w_data_i, w_sel_i);
    end
`endif
  end

  // Force read data to zero for as long as reset is asserted.
  always_comb begin
    r_data1_o = '0;
    r_data2_o = '0;
    if (rst_n) begin
      r_data1_o = rd1;
      r_data2_o = rd2;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed vectors with hand-computed values,
// then a randomized phase compared against a byte-masked reference model.
// Build with and without RAM_WRITE_BYPASS_EN.
module tb_ram;

  localparam int DEPTH   = 16384;
  localparam int IDX_W   = 14;
  localparam int N_RAND  = 3000;

  logic        clk;
  logic        rst_n;
  logic [31:0] r_addr1_i;
  logic [31:0] r_addr2_i;
  logic        w_en_i;
  logic [31:0] w_addr_i;
  logic [31:0] w_data_i;
  logic [3:0]  w_sel_i;
  logic [31:0] r_data1_o;
  logic [31:0] r_data2_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [DEPTH];

  ram #(
    .RAM_DEPTH         (DEPTH),
    .RAM_DEPTH_BIT_LEN (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_addr1_i (r_addr1_i),
    .r_addr2_i (r_addr2_i),
    .w_en_i    (w_en_i),
    .w_addr_i  (w_addr_i),
    .w_data_i  (w_data_i),
    .w_sel_i   (w_sel_i),
    .r_data1_o (r_data1_o),
    .r_data2_o (r_data2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  // Expected combinational read of 'addr' given current inputs and model.
  function automatic logic [31:0] exp_read(input logic [31:0] addr);
    logic [31:0] e;
    e = model[addr[IDX_W-1:0]];
`ifdef RAM_WRITE_BYPASS_EN
    if (w_en_i && addr[IDX_W-1:0] == w_addr_i[IDX_W-1:0]) e = mrg(e, w_data_i, w_sel_i);
`endif
    if (!rst_n) e = 32'h0;
    return e;
  endfunction

  task automatic set_write(input logic en, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
    w_en_i   = en;
    w_addr_i = addr;
    w_data_i = data;
    w_sel_i  = sel;
  endtask

  // Advance one edge, mirror the write into the model, then idle the write port.
  task automatic clock_edge();
    @(posedge clk);
    if (w_en_i && rst_n) model[w_addr_i[IDX_W-1:0]] = mrg(model[w_addr_i[IDX_W-1:0]], w_data_i, w_sel_i);
    #1;
    w_en_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] sel);
    set_write(1'b1, addr, data, sel);
    clock_edge();
  endtask

  initial begin
    logic [31:0] base_hi;
    logic [31:0] a1;
    logic [31:0] a2;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    r_addr1_i = 32'd10;
    r_addr2_i = 32'd10;
    set_write(1'b0, 32'd0, 32'd0, 4'h0);
    #1;
    check_eq("reset_rd1", r_data1_o, 32'h0);
    check_eq("reset_rd2", r_data2_o, 32'h0);

    // Write attempt during reset must be ignored.
    @(posedge clk); #1;
    wr(32'd10, 32'h12345678, 4'hF);
    check_eq("reset_wr_rd1", r_data1_o, 32'h0);
    check_eq("reset_wr_rd2", r_data2_o, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("post_reset_old1", r_data1_o, 32'h0);
    check_eq("post_reset_old2", r_data2_o, 32'h0);

    // Full write.
    wr(32'd10, 32'hDEADBEEF, 4'hF);
    #1;
    check_eq("full_wr_rd1", r_data1_o, 32'hDEADBEEF);
    check_eq("same_addr_rd2", r_data2_o, 32'hDEADBEEF);

    // Partial write; observe before and after the edge.
    set_write(1'b1, 32'd10, 32'h11223344, 4'b0101);
    #1;
`ifdef RAM_WRITE_BYPASS_EN
    check_eq("pre_edge_bypass", r_data1_o, 32'hDE22BE44);
`else
    check_eq("pre_edge_old", r_data1_o, 32'hDEADBEEF);
`endif
    clock_edge();
    check_eq("partial_wr", r_data1_o, 32'hDE22BE44);

    // Disabled write and empty lane mask.
    set_write(1'b0, 32'd10, 32'hFFFFFFFF, 4'hF);
    clock_edge();
    check_eq("wen0_noop", r_data1_o, 32'hDE22BE44);
    wr(32'd10, 32'hFFFFFFFF, 4'h0);
    check_eq("sel0_noop", r_data1_o, 32'hDE22BE44);

    // Dual read and address wrap.
    wr(32'd5, 32'hA5A5A5A5, 4'hF);
    wr(32'd6, 32'h5A5A5A5A, 4'hF);
    r_addr1_i = 32'd5;
    r_addr2_i = 32'd6;
    #1;
    check_eq("dual_rd1", r_data1_o, 32'hA5A5A5A5);
    check_eq("dual_rd2", r_data2_o, 32'h5A5A5A5A);
    r_addr1_i = 32'd16384 + 32'd5;
    #1;
    check_eq("wrap_rd1", r_data1_o, 32'hA5A5A5A5);
    wr(32'd49152 + 32'd7, 32'h0BADF00D, 4'b0011);
    r_addr2_i = 32'd7;
    #1;
    check_eq("wrap_wr_rd2", r_data2_o, 32'h0000F00D);

    // Asynchronous reset mid-run: outputs zero, contents retained.
    r_addr1_i = 32'd5;
    r_addr2_i = 32'd10;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_rd1", r_data1_o, 32'h0);
    check_eq("async_rst_rd2", r_data2_o, 32'h0);
    wr(32'd5, 32'h00000000, 4'hF);
    rst_n = 1'b1;
    #1;
    check_eq("retain_rd1", r_data1_o, 32'hA5A5A5A5);
    check_eq("retain_rd2", r_data2_o, 32'hDE22BE44);

    // Randomized traffic with incrementing addresses against the model.
    for (int i = 0; i < N_RAND; i++) begin
      base_hi = {$urandom_range(0, 3), 14'd0};
      a1 = base_hi + 32'(i);
      a2 = {$urandom_range(0, 3), 14'd0} + 32'(i) - 32'd1;
      set_write(1'($urandom), {$urandom_range(0, 3), 14'd0} + 32'(i),
                $urandom, 4'($urandom));
      r_addr1_i = a1;
      r_addr2_i = a2;
      #1;
      check_eq("rand_rd1", r_data1_o, exp_read(a1));
      check_eq("rand_rd2", r_data2_o, exp_read(a2));
      clock_edge();
    end

    // Read back the randomized region after the traffic has settled.
    for (int i = 0; i < 64; i++) begin
      r_addr1_i = 32'(i);
      r_addr2_i = 32'(N_RAND - 1 - i);
      #1;
      check_eq("final_rd1", r_data1_o, exp_read(r_addr1_i));
      check_eq("final_rd2", r_data2_o, exp_read(r_addr2_i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
